// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq
// Description : Instruction-fetch sequencer. Owns the fetch PC, issues one
//               WIDTH-instruction bundle request at a time to the instruction
//               memory, holds the returned bundle in a one-entry buffer for
//               decode, applies predictor and resolve redirects, and drops
//               stale responses that belong to a pre-redirect request.
//
// Ports:
//   clock            : single clock, all state changes on posedge
//   reset            : asynchronous, active-high
//   mem_req_valid    : fetch request valid
//   mem_req_addr     : bundle PC being requested
//   mem_req_ready    : memory accepts the request this cycle
//   mem_resp_valid   : response data valid (cannot be back-pressured)
//   mem_resp_data    : lane i in bits [32*i+31:32*i]
//   predict_valid    : predictor redirect for the bundle returning this cycle
//   predict_dst      : predicted target
//   resolve_valid    : resolve event
//   resolve_redirect : resolve requires a redirect (mispredict)
//   resolve_dst      : corrected target
//   dec_valid        : per-lane valid, all ones while the buffer is full
//   dec_inst         : buffered instructions
//   dec_pc           : lane i = bundle_pc + 4*i
//   dec_ready        : decode consumes the whole bundle this cycle
//   flush_count      : saturating count of resolve redirects
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq #(
    parameter int          WIDTH    = 2,
    parameter int          XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_req_valid,
    output logic [XLEN-1:0]       mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [WIDTH*32-1:0]   mem_resp_data,
    input  logic                  predict_valid,
    input  logic [XLEN-1:0]       predict_dst,
    input  logic                  resolve_valid,
    input  logic                  resolve_redirect,
    input  logic [XLEN-1:0]       resolve_dst,
    output logic [WIDTH-1:0]      dec_valid,
    output logic [WIDTH*32-1:0]   dec_inst,
    output logic [WIDTH*XLEN-1:0] dec_pc,
    input  logic                  dec_ready,
    output logic [7:0]            flush_count
);

    localparam logic [XLEN-1:0] c_BUNDLE_STEP = XLEN'(4 * WIDTH);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       w_pc_nxt;
    logic                  r_buf_valid;
    logic [WIDTH*32-1:0]   r_buf_data;
    logic [XLEN-1:0]       r_buf_pc;
    logic [7:0]            r_flush_count;

    logic                  w_redirect;
    logic                  w_req_valid;
    logic                  w_req_fire;
    logic                  w_fill;

    assign w_redirect = resolve_valid && resolve_redirect;
    assign w_req_fire = w_req_valid && mem_req_ready;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fill      = 1'b0;
        w_req_valid = 1'b0;

        case (r_state)
            ST_REQ: begin
                // A new request may only go out when the buffer will be free
                // by the time its response returns; the response cannot be
                // stalled, so this keeps the one-entry buffer sufficient.
                w_req_valid = !reset && (!r_buf_valid || dec_ready);
                if (w_req_valid && mem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    w_fill      = 1'b1;
                    w_pc_nxt    = predict_valid ? predict_dst : (r_pc + c_BUNDLE_STEP);
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // Response belongs to a request issued before a redirect.
                if (mem_resp_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase

        // Resolve redirect overrides everything above. If a request is
        // (or was) in flight, its response must still be absorbed in DRAIN.
        if (w_redirect) begin
            w_fill   = 1'b0;
            w_pc_nxt = resolve_dst;
            case (r_state)
                ST_REQ:  w_state_nxt = w_req_fire ? ST_DRAIN : ST_REQ;
                default: w_state_nxt = mem_resp_valid ? ST_REQ : ST_DRAIN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // One-entry decode buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
            r_buf_pc    <= '0;
        end else if (w_redirect) begin
            r_buf_valid <= 1'b0;
        end else if (w_fill) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= mem_resp_data;
            r_buf_pc    <= r_pc;
        end else if (dec_ready) begin
            r_buf_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating redirect counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_flush_count <= 8'd0;
        end else if (w_redirect && (r_flush_count != 8'hFF)) begin
            r_flush_count <= r_flush_count + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = r_pc;
    assign dec_valid     = {WIDTH{r_buf_valid}};
    assign dec_inst      = r_buf_data;
    assign flush_count   = r_flush_count;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane_pc
            assign dec_pc[gi*XLEN +: XLEN] = r_buf_pc + XLEN'(4 * gi);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_seq
// Description : Directed self-checking bench for fetch_seq (WIDTH=2, XLEN=32,
//               RESET_PC=0). The bench plays the instruction memory by hand,
//               one cycle at a time, and compares against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b1;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        predict_valid = 1'b0;
    logic [31:0] predict_dst = '0;
    logic        resolve_valid = 1'b0;
    logic        resolve_redirect = 1'b0;
    logic [31:0] resolve_dst = '0;
    logic [1:0]  dec_valid;
    logic [63:0] dec_inst;
    logic [63:0] dec_pc;
    logic        dec_ready = 1'b1;
    logic [7:0]  flush_count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_seq #(.WIDTH(2), .XLEN(32), .RESET_PC(32'h0)) dut (
        .clock            (clock),
        .reset            (reset),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_ready    (mem_req_ready),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .predict_valid    (predict_valid),
        .predict_dst      (predict_dst),
        .resolve_valid    (resolve_valid),
        .resolve_redirect (resolve_redirect),
        .resolve_dst      (resolve_dst),
        .dec_valid        (dec_valid),
        .dec_inst         (dec_inst),
        .dec_pc           (dec_pc),
        .dec_ready        (dec_ready),
        .flush_count      (flush_count)
    );

    always #5 clock = ~clock;

    // Memory contents: each lane word is its own address xor a tag.
    function automatic logic [63:0] bundle(input logic [31:0] a);
        logic [31:0] a1;
        a1 = a + 32'd4;
        return {a1 ^ 32'hDEAD_0000, a ^ 32'hDEAD_0000};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to the next negedge and drop all single-cycle pulse inputs.
    task automatic nc();
        @(negedge clock);
        mem_resp_valid   = 1'b0;
        mem_resp_data    = '0;
        predict_valid    = 1'b0;
        resolve_valid    = 1'b0;
        resolve_redirect = 1'b0;
    endtask

    task automatic resp(input logic [31:0] a);
        mem_resp_valid = 1'b1;
        mem_resp_data  = bundle(a);
    endtask

    task automatic redirect(input logic [31:0] dst);
        resolve_valid    = 1'b1;
        resolve_redirect = 1'b1;
        resolve_dst      = dst;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        #1;
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_flush", 64'(flush_count), 64'd0);

        // Reset release: first request at 0x0
        nc(); reset = 1'b0; #1;
        check("req0_valid", 64'(mem_req_valid), 64'd1);
        check("req0_addr", 64'(mem_req_addr), 64'h0);

        nc(); resp(32'h0); #1;                    // WAIT
        check("wait_no_req", 64'(mem_req_valid), 64'd0);
        check("wait_dec_empty", 64'(dec_valid), 64'd0);

        nc(); #1;                                  // buffer full, dec_ready=1
        check("b0_dec_valid", 64'(dec_valid), 64'h3);
        check("b0_dec_pc", dec_pc, 64'h0000_0004_0000_0000);
        check("b0_dec_inst", dec_inst, bundle(32'h0));
        check("req8_valid", 64'(mem_req_valid), 64'd1);
        check("req8_addr", 64'(mem_req_addr), 64'h8);

        // Response for 0x8, then stall decode for 5 cycles
        nc(); dec_ready = 1'b0; resp(32'h8); #1;
        check("consumed_b0", 64'(dec_valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            nc(); #1;
            check("stall_req_valid", 64'(mem_req_valid), 64'd0);
            check("stall_dec_valid", 64'(dec_valid), 64'h3);
            check("stall_dec_pc", dec_pc, 64'h0000_000C_0000_0008);
            check("stall_dec_inst", dec_inst, bundle(32'h8));
        end
        nc(); dec_ready = 1'b1; #1;                // request issues same cycle
        check("unstall_req_valid", 64'(mem_req_valid), 64'd1);
        check("unstall_req_addr", 64'(mem_req_addr), 64'h10);

        // Predict on response cycle for bundle 0x10 -> 0x100
        nc(); resp(32'h10); predict_valid = 1'b1; predict_dst = 32'h100; #1;
        nc(); predict_valid = 1'b1; predict_dst = 32'h400; #1;   // ignored in REQ
        check("pred_dec_pc", dec_pc, 64'h0000_0014_0000_0010);
        check("pred_req_addr", 64'(mem_req_addr), 64'h100);
        nc(); resp(32'h100); #1;
        nc(); #1;
        check("pred_req_ignored", 64'(mem_req_addr), 64'h108);
        check("b100_dec_pc", dec_pc, 64'h0000_0104_0000_0100);

        // Redirect in WAIT to 0x200; stale response 3 cycles later
        nc(); redirect(32'h200); #1;
        nc(); #1;
        check("drain_no_req", 64'(mem_req_valid), 64'd0);
        check("flush_1", 64'(flush_count), 64'd1);
        nc(); #1;
        nc(); resp(32'h108); #1;
        nc(); #1;
        check("stale_dropped", 64'(dec_valid), 64'd0);
        check("req200_valid", 64'(mem_req_valid), 64'd1);
        check("req200_addr", 64'(mem_req_addr), 64'h200);

        // Buffer held, redirect in REQ without a request -> flush buffer
        nc(); resp(32'h200); #1;
        nc(); dec_ready = 1'b0; #1;
        check("b200_held", 64'(dec_valid), 64'h3);
        nc(); redirect(32'h300); #1;
        nc(); dec_ready = 1'b1; #1;
        check("held_flushed", 64'(dec_valid), 64'd0);
        check("req300_addr", 64'(mem_req_addr), 64'h300);
        check("req300_valid", 64'(mem_req_valid), 64'd1);
        check("flush_2", 64'(flush_count), 64'd2);

        // Redirect on the response cycle -> data dropped, REQ
        nc(); resp(32'h300); redirect(32'h500); #1;
        nc(); redirect(32'h600); #1;               // redirect while request accepted
        check("resp_redirect_drop", 64'(dec_valid), 64'd0);
        check("req500_addr", 64'(mem_req_addr), 64'h500);
        check("req500_valid", 64'(mem_req_valid), 64'd1);
        check("flush_3", 64'(flush_count), 64'd3);
        nc(); redirect(32'h700); #1;               // DRAIN, no response
        check("drain_after_accept", 64'(mem_req_valid), 64'd0);
        nc(); resp(32'h500); #1;
        check("drain2_no_req", 64'(mem_req_valid), 64'd0);
        nc(); resolve_valid = 1'b1; resolve_redirect = 1'b0; resolve_dst = 32'h900; #1;
        check("req700_addr", 64'(mem_req_addr), 64'h700);
        check("flush_5", 64'(flush_count), 64'd5);
        nc(); resp(32'h700); #1;
        nc(); dec_ready = 1'b0; redirect(32'hFFFF_FFF8); #1;
        check("b700_dec_pc", dec_pc, 64'h0000_0704_0000_0700);
        check("no_redirect_effect", 64'(mem_req_addr), 64'h708);

        // PC wrap
        nc(); dec_ready = 1'b1; #1;
        check("wrap_req_addr", 64'(mem_req_addr), 64'hFFFF_FFF8);
        check("flush_6", 64'(flush_count), 64'd6);
        nc(); resp(32'hFFFF_FFF8); #1;
        nc(); #1;
        check("wrap_dec_pc", dec_pc, 64'hFFFF_FFFC_FFFF_FFF8);
        check("wrap_next_addr", 64'(mem_req_addr), 64'h0);

        // Saturation of flush_count
        for (int i = 0; i < 300; i++) begin
            nc(); redirect(32'h40); #1;
            if (i == 248) check("flush_254", 64'(flush_count), 64'd254);
            if (i == 249) check("flush_255", 64'(flush_count), 64'd255);
        end
        nc(); #1;
        check("flush_sat", 64'(flush_count), 64'd255);
        nc(); resp(32'h0); #1;
        nc(); #1;
        check("req40_addr", 64'(mem_req_addr), 64'h40);

        // Reset mid-WAIT, redirect in the release cycle
        nc(); reset = 1'b1; #1;
        check("midrst_req_valid", 64'(mem_req_valid), 64'd0);
        check("midrst_flush", 64'(flush_count), 64'd0);
        check("midrst_dec_valid", 64'(dec_valid), 64'd0);
        nc(); reset = 1'b0; redirect(32'h800); #1;
        check("rel_req_valid", 64'(mem_req_valid), 64'd1);
        check("rel_req_addr", 64'(mem_req_addr), 64'h0);
        nc(); resp(32'h0); #1;
        check("rel_flush", 64'(flush_count), 64'd1);
        check("rel_drain", 64'(mem_req_valid), 64'd0);
        nc(); #1;
        check("req800_addr", 64'(mem_req_addr), 64'h800);
        check("req800_valid", 64'(mem_req_valid), 64'd1);
        check("rel_dec_valid", 64'(dec_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
